list_fetch_sched: RTL
=====================

// Module: list_fetch_sched
// PURPOSE
//  Shares one upstream cacheline fetch engine between NREQ list_cache consumers.
//  - Round-robin arbitrates fetch requests and issues one fetch command per grant.
//  - Routes the returning AXI4-Stream beats to the granted consumer until the burst completes.
//  - Sits between the DMA/stream source and the list_cache instances of the HoP list datapath.
// PARAMETERS
//  NREQ   4    number of list_cache requesters (2..16)
//  DBW    256  stream data width in bits (one beat = one cacheline)
//  BURST  2    beats per fetch (= cache buffer depth of a consumer), 1..256
// PORTS
//  ACLK       in   1          clock; single clock domain
//  ARESET     in   1          asynchronous, active-high reset
//  REQ        in   NREQ       per-requester level fetch request
//  GNT        out  NREQ       one-hot grant, held from command issue to last beat
//  CMD_VALID  out  1          fetch command valid to fetch engine
//  CMD_READY  in   1          fetch engine accepts command
//  CMD_ID     out  $clog2(NREQ)  granted requester index (engine echoes it on S_TDEST)
//  CMD_LEN    out  8          BURST-1
//  S_TDATA    in   DBW        upstream beat data
//  S_TVALID   in   1          upstream beat valid
//  S_TREADY   out  1          upstream beat ready
//  S_TLAST    in   1          last beat of burst
//  S_TDEST    in   4          destination tag
//  M_TDATA    out  DBW        beat data, broadcast to all requesters
//  M_TVALID   out  NREQ       per-requester beat valid
//  M_TREADY   in   NREQ       per-requester beat ready
//  M_TLAST    out  1          S_TLAST pass-through
//  BUSY       out  1          FSM not in IDLE
//  ERR        out  1          sticky destination error (LIST_SCHED_DEST_CHECK_EN only, else 0)
// BEHAVIOUR
//  - Reset (async): GNT=0, CMD_VALID=0, M_TVALID=0, S_TREADY=0, BUSY=0, ERR=0, beat_cnt=0, state=IDLE.
//    The round-robin pointer resets so requester 0 has top priority.
//    Reset mid-burst abandons the burst; no beat is forwarded after ARESET rises.
//  - FSM IDLE -> CMD -> XFER -> IDLE.
//  - IDLE: when |REQ, pick the first set REQ at or after (last_gnt+1) mod NREQ.
//    Register GNT/CMD_ID; CMD_VALID=1 from the next cycle (1-cycle REQ->CMD_VALID latency).
//  - CMD: hold CMD_VALID/CMD_ID stable until CMD_READY; on the handshake, go to XFER with beat_cnt=0.
//  - XFER is a combinational pass-through (zero latency):
//    M_TDATA=S_TDATA, M_TVALID[g]=S_TVALID, other M_TVALID=0, S_TREADY=M_TREADY[g].
//  - Beat accepted when S_TVALID&S_TREADY; beat_cnt increments (8-bit, saturates at BURST-1).
//  - Burst ends on the accepted beat with S_TLAST=1 OR beat_cnt==BURST-1, whichever comes first.
//    On end: last_gnt<=g, GNT<=0, state<=IDLE.
//    Next arbitration happens the following cycle, so there is 1 idle cycle minimum between bursts.
//  - Outside XFER: S_TREADY=0 and M_TVALID=0. Upstream beats stall and are never dropped.
//  - Deasserting REQ during CMD/XFER does not abort; the burst completes.
//  - A requester holding REQ continuously gets at most 1 grant per NREQ grants while others request.
//  - Only one request, repeatedly: it is re-granted back-to-back (1 idle cycle between bursts).
// CONFIGURATION
//  LIST_SCHED_DEST_CHECK_EN defined:
//  - In XFER, an accepted beat with S_TDEST != CMD_ID is dropped: S_TREADY=1, M_TVALID all 0.
//  - ERR is set the next cycle and stays set until ARESET. beat_cnt still advances.
//  Not defined: S_TDEST is ignored, ERR tied 0.
// STRUCTURE
//  - Package list_sched_pkg holds:
//    - state_t enum {IDLE, CMD, XFER};
//    - localparam LEN_W=8;
//    - function idx_w(n)=$clog2(n).
//  - Sub-module rr_arbiter #(N): REQ, last pointer -> one-hot grant + index. Purely combinational.
//  - FSM, counters and routing stay in list_fetch_sched.
// TESTING
//  - Single requester: REQ=0001 -> CMD_VALID cycle+1, CMD_ID=0, CMD_LEN=1.
//    2 beats (D0, D1 with TLAST) reach M_TVALID[0] only; BUSY back to 0 after D1.
//  - Fairness: REQ=1111 held for 8 bursts -> grant order 0,1,2,3,0,1,2,3.
//  - Backpressure: CMD_READY low 5 cycles -> CMD_VALID/CMD_ID held stable.
//    M_TREADY[g]=0 for 3 cycles mid-burst -> S_TREADY=0, no beat lost or duplicated.
//  - Early TLAST: BURST=4, TLAST on beat 1 -> burst ends after 2 beats, next grant proceeds.
//  - Async reset asserted mid-XFER after beat 0 -> all outputs 0 immediately.
//    After release, REQ=0100 -> CMD_ID=2 with a fresh beat_cnt.
//  - DEST_CHECK_EN: CMD_ID=1, beat with S_TDEST=3 -> beat dropped, ERR=1 next cycle and sticky.

Source files
------------

// File: rtl/list_sched_pkg.sv
// Shared types and helpers for the list fetch scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package list_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        XFER = 2'd2
    } state_t;

    // Width of the fetch length field (beats - 1).
    localparam int LEN_W = 8;

    // Index width for an n-entry requester set.
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after (last + 1) mod N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when to register the result.
//
// Ports:
//   req   in   N        request vector
//   last  in   idx_w(N) index of the most recently served requester
//   gnt   out  N        one-hot winner (0 when no request)
//   idx   out  idx_w(N) winner index (0 when no request)
//   any   out  1        at least one request present
module rr_arbiter
    import list_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   last,
    output logic [N-1:0]          gnt,
    output logic [idx_w(N)-1:0]   idx,
    output logic                  any
);

    localparam int IW = idx_w(N);

    always_comb begin
        int k;
        k   = 0;
        gnt = '0;
        idx = '0;
        any = |req;
        // Walk from the farthest candidate back to the nearest so the
        // nearest set request after 'last' overwrites any earlier hit.
        for (int i = N; i >= 1; i--) begin
            k = int'(last) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/list_fetch_sched.sv
// Shares one cacheline fetch engine between NREQ list_cache consumers (round-robin).
// Latency: REQ -> CMD_VALID 1 cycle; stream beats pass through combinationally (0 cycles).
// Backpressure: S_TREADY follows the granted consumer's M_TREADY; beats stall, never drop.
//
// Optional feature macro: LIST_SCHED_DEST_CHECK_EN (beats whose S_TDEST differs from
// CMD_ID are swallowed and ERR latches high; when undefined S_TDEST is ignored, ERR=0).
//
// Ports:
//   ACLK, ARESET                  clock, async active-high reset
//   REQ[NREQ]                     level fetch requests
//   GNT[NREQ]                     one-hot grant, command issue through last beat
//   CMD_VALID/READY, CMD_ID, CMD_LEN  fetch command to the engine (CMD_LEN = BURST-1)
//   S_TDATA/TVALID/TREADY/TLAST/TDEST upstream beats
//   M_TDATA, M_TVALID[NREQ], M_TREADY[NREQ], M_TLAST  routed beats to consumers
//   BUSY                          scheduler not idle
//   ERR                           sticky destination mismatch
module list_fetch_sched
    import list_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DBW   = 256,
    parameter int BURST = 2
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NREQ-1:0]           REQ,
    output logic [NREQ-1:0]           GNT,
    output logic                      CMD_VALID,
    input  logic                      CMD_READY,
    output logic [idx_w(NREQ)-1:0]    CMD_ID,
    output logic [LEN_W-1:0]          CMD_LEN,
    input  logic [DBW-1:0]            S_TDATA,
    input  logic                      S_TVALID,
    output logic                      S_TREADY,
    input  logic                      S_TLAST,
    input  logic [3:0]                S_TDEST,
    output logic [DBW-1:0]            M_TDATA,
    output logic [NREQ-1:0]           M_TVALID,
    input  logic [NREQ-1:0]           M_TREADY,
    output logic                      M_TLAST,
    output logic                      BUSY,
    output logic                      ERR
);

    localparam int               IW       = idx_w(NREQ);
    localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(BURST - 1);

    state_t              state;
    logic [NREQ-1:0]     gnt_q;
    logic [IW-1:0]       cmd_id_q;
    logic [IW-1:0]       last_gnt;
    logic                cmd_valid_q;
    logic [LEN_W-1:0]    beat_cnt;
    logic                err_q;

    logic [NREQ-1:0]     arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;

    logic                in_xfer;
    logic                dest_ok;
    logic                beat_acc;
    logic                burst_end;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req  (REQ),
        .last (last_gnt),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    assign in_xfer = (state == XFER);

`ifdef LIST_SCHED_DEST_CHECK_EN
    assign dest_ok = (S_TDEST == 4'(cmd_id_q));
`else
    logic unused_dest;
    assign unused_dest = ^S_TDEST;
    assign dest_ok     = 1'b1;
`endif

    // Routing is a pure pass-through while transferring. A misdirected beat is
    // accepted upstream (so the engine drains) but shown to no consumer.
    always_comb begin
        M_TVALID = '0;
        S_TREADY = 1'b0;
        if (in_xfer) begin
            S_TREADY = M_TREADY[cmd_id_q] | ~dest_ok;
            if (dest_ok) begin
                M_TVALID[cmd_id_q] = S_TVALID;
            end
        end
    end

    assign M_TDATA   = S_TDATA;
    assign M_TLAST   = S_TLAST;
    assign beat_acc  = in_xfer & S_TVALID & S_TREADY;
    // Early TLAST or a full count both close the burst, whichever comes first.
    assign burst_end = beat_acc & (S_TLAST | (beat_cnt == LAST_CNT));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= IDLE;
            gnt_q       <= '0;
            cmd_id_q    <= '0;
            cmd_valid_q <= 1'b0;
            beat_cnt    <= '0;
            // Pointer at the top index makes requester 0 the first candidate.
            last_gnt    <= IW'(NREQ - 1);
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt_q       <= arb_gnt;
                        cmd_id_q    <= arb_idx;
                        cmd_valid_q <= 1'b1;
                        state       <= CMD;
                    end
                end
                CMD: begin
                    if (CMD_READY) begin
                        cmd_valid_q <= 1'b0;
                        beat_cnt    <= '0;
                        state       <= XFER;
                    end
                end
                XFER: begin
                    if (beat_acc && (beat_cnt != LAST_CNT)) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                    end
                    if (burst_end) begin
                        last_gnt <= cmd_id_q;
                        gnt_q    <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (beat_acc && !dest_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    assign GNT       = gnt_q;
    assign CMD_VALID = cmd_valid_q;
    assign CMD_ID    = cmd_id_q;
    assign CMD_LEN   = LAST_CNT;
    assign BUSY      = (state != IDLE);
    assign ERR       = err_q;

endmodule
